// File: rtl/branch_ctrl.sv
// Branch resolution controller for an RV32I pipeline.
// Accepts one conditional branch at a time, waits for the hazard unit to
// release valid operands, resolves the branch from the comparator flags and
// redirects the PC for one cycle when the branch is taken. Keeps saturating
// counters of resolved and taken branches.
`timescale 1ns/1ps
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [2:0]  br_funct3,
  input  logic        operands_ready,
  input  logic        cnt_clr,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  output logic        br_ready,
  output logic        stall,
  output logic        pc_sel,
  output logic        flush,
  output logic        illegal,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    RESOLVE,
    REDIRECT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  funct3_q;
  logic        funct3_bad;
  logic        taken;
  logic        resolving;
  logic [15:0] branch_cnt_next;
  logic [15:0] taken_cnt_next;

  // funct3 010/011 are not branch encodings; they resolve as never taken
  assign funct3_bad = (funct3_q[2:1] == 2'b01);
  assign resolving  = (state == RESOLVE);

  // Taken decision from the latched funct3 and the comparator flags
  always_comb begin
    taken = 1'b0;
    case (funct3_q)
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLT;
      3'b101, 3'b111: taken = !BrLT;
      default:        taken = 1'b0;
    endcase
  end

  // Next-state logic and state-decoded control outputs
  always_comb begin
    state_next = state;
    br_ready   = 1'b0;
    stall      = 1'b0;
    pc_sel     = 1'b0;
    flush      = 1'b0;
    BrUn       = (funct3_q[2:1] == 2'b11);
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          state_next = operands_ready ? RESOLVE : WAIT_OPS;
        end
      end
      WAIT_OPS: begin
        stall = 1'b1;
        if (operands_ready) begin
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        stall      = 1'b1;
        state_next = taken ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        pc_sel     = 1'b1;
        flush      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating statistics; a clear beats an increment in the same cycle
  always_comb begin
    branch_cnt_next = branch_cnt;
    taken_cnt_next  = taken_cnt;
    if (cnt_clr) begin
      branch_cnt_next = 16'h0000;
      taken_cnt_next  = 16'h0000;
    end else if (resolving && !funct3_bad) begin
      if (branch_cnt != 16'hFFFF) begin
        branch_cnt_next = branch_cnt + 16'd1;
      end
      if (taken && (taken_cnt != 16'hFFFF)) begin
        taken_cnt_next = taken_cnt + 16'd1;
      end
    end
  end

  // State register, latched funct3, illegal pulse and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      illegal    <= 1'b0;
      branch_cnt <= 16'h0000;
      taken_cnt  <= 16'h0000;
    end else begin
      state      <= state_next;
      illegal    <= resolving && funct3_bad;
      branch_cnt <= branch_cnt_next;
      taken_cnt  <= taken_cnt_next;
      if ((state == IDLE) && br_valid) begin
        funct3_q <= br_funct3;
      end
    end
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  branch instruction offered this cycle
- br_funct3  in  3  RV32I branch funct3 of offered instruction
- operands_ready  in  1  hazard unit: rs1/rs2 values valid at comparator inputs
- cnt_clr  in  1  synchronous clear of statistics counters
- BrEq  in  1  comparator: operand_0 == operand_1
- BrLT  in  1  comparator: operand_0 < operand_1 (signed or unsigned per BrUn)
- BrUn  out  1  comparator mode, 1 = unsigned
- br_ready  out  1  controller can accept a branch
- stall  out  1  hold fetch/decode
- pc_sel  out  1  1 = redirect PC to branch target
- flush  out  1  squash younger instructions
- illegal  out  1  one-cycle pulse, funct3 010/011 offered
- branch_cnt  out  16  resolved legal branches, saturating
- taken_cnt  out  16  taken branches, saturating

Function
REQ-003 FSM states SHALL be IDLE, WAIT_OPS, RESOLVE, REDIRECT.
REQ-004 br_ready SHALL be 1 only in IDLE; br_valid outside IDLE SHALL be ignored.
REQ-005 IDLE: on br_valid, funct3_q <= br_funct3; next state RESOLVE if operands_ready, else WAIT_OPS; without br_valid, stay IDLE.
REQ-006 WAIT_OPS: stall=1; advance to RESOLVE on first cycle with operands_ready=1; no timeout.
REQ-007 RESOLVE: stall=1; lasts exactly one cycle; BrEq/BrLT sampled at its end.
REQ-008 BrUn SHALL equal 1 iff funct3_q is 110 or 111, in every state; it is 0 otherwise.
REQ-009 Taken decision: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT; 010/011 never taken.
REQ-010 From RESOLVE: taken -> REDIRECT; otherwise -> IDLE.
REQ-011 REDIRECT: pc_sel=1, flush=1, stall=0, exactly one cycle, then IDLE.
REQ-012 pc_sel and flush SHALL be 0 in all states other than REDIRECT.
REQ-013 illegal SHALL pulse for exactly one cycle, the cycle following RESOLVE, when funct3_q is 010/011.
REQ-014 Latency: branch accepted in cycle N with operands_ready -> RESOLVE in N+1 -> REDIRECT (taken) or IDLE (not taken) in N+2; each WAIT_OPS cycle adds one.
REQ-015 On leaving RESOLVE with legal funct3, branch_cnt SHALL increment; taken_cnt SHALL also increment if taken; illegal funct3 increments neither.
REQ-016 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-017 cnt_clr SHALL zero both counters next edge and win over a simultaneous increment.
REQ-018 Outputs stall, pc_sel, flush, br_ready, BrUn SHALL decode from state/funct3_q only (no input-to-output combinational path).

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, funct3_q 000, counters 0, illegal 0.
REQ-020 Reset values: br_ready 1, stall 0, pc_sel 0, flush 0, BrUn 0, illegal 0, branch_cnt 0, taken_cnt 0.
REQ-021 Reset asserted mid-operation (WAIT_OPS/RESOLVE/REDIRECT) SHALL abandon the branch with no counter update and no pc_sel/flush pulse.

Verification
REQ-022 BEQ: funct3 000, operands_ready 1, BrEq 1 in RESOLVE -> pc_sel=flush=1 one cycle at N+2; branch_cnt 1, taken_cnt 1.
REQ-023 BLTU not taken: funct3 110, BrUn=1 in RESOLVE, BrLT 0 -> IDLE at N+2, pc_sel 0, branch_cnt +1, taken_cnt unchanged.
REQ-024 Operand hazard: br_valid with operands_ready 0 for 3 cycles -> stall=1 for 3 WAIT_OPS cycles + RESOLVE; br_valid pulses meanwhile ignored.
REQ-025 Illegal: funct3 011 -> illegal pulses once at N+2, no redirect, counters unchanged.
REQ-026 Saturation/clear: preload 65535 taken branches -> both counters 16'hFFFF; one more taken -> still FFFF; cnt_clr concurrent with an increment -> both 0.
REQ-027 rst_n low during WAIT_OPS -> next cycle br_ready 1, stall 0, counters 0, no flush.
